// File: rtl/bcd_multidigito.sv
// N-digit up/down BCD counter with output latch and a scanned 7-segment driver.
// Define BCD_BLANK_EN to blank leading zero digits on the display.
module bcd_multidigito #(
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  ck,
    input  logic                  rst_s,
    input  logic                  enb,
    input  logic                  up,
    input  logic                  ld,
    output logic [4*DIGITS-1:0]   q,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            sgm,
    output logic                  cnt_max
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] q_q;
    logic [PW-1:0]          pre_q, pre_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic                   carry;
    logic                   all9, all0;
    logic [3:0]             sel_dig;
`ifdef BCD_BLANK_EN
    logic                   hi_zero;
    logic                   blank;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Ripple the step through the decades; a digit moves only while every lower digit wraps.
    always_comb begin
        cnt_d = cnt_q;
        carry = enb;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (up) cnt_d[k] = (cnt_q[k] == 4'd9) ? 4'd0 : cnt_q[k] + 4'd1;
                else    cnt_d[k] = (cnt_q[k] == 4'd0) ? 4'd9 : cnt_q[k] - 4'd1;
            end
            carry = carry & (up ? (cnt_q[k] == 4'd9) : (cnt_q[k] == 4'd0));
        end
    end

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            all9 = all9 & (cnt_q[k] == 4'd9);
            all0 = all0 & (cnt_q[k] == 4'd0);
        end
        cnt_max = up ? all9 : all0;
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        an_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = (idx_d == IW'(k));
        end
    end

    // Display path reads the latch combinationally so sgm lines up with the registered an.
    always_comb begin
        sel_dig = 4'd0;
`ifdef BCD_BLANK_EN
        hi_zero = 1'b1;
        blank   = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef BCD_BLANK_EN
            hi_zero = hi_zero & (q_q[k] == 4'd0);
`endif
            if (idx_q == IW'(k)) begin
                sel_dig = q_q[k];
`ifdef BCD_BLANK_EN
                blank = hi_zero & (k != 0);
`endif
            end
        end
`ifdef BCD_BLANK_EN
        sgm = blank ? 7'b0000000 : seg7(sel_dig);
`else
        sgm = seg7(sel_dig);
`endif
    end

    always_ff @(posedge ck) begin
        if (rst_s) begin
            cnt_q <= '0;
            q_q   <= '0;
            pre_q <= '0;
            idx_q <= '0;
            an_q  <= DIGITS'(1);
        end else begin
            cnt_q <= cnt_d;
            if (ld) q_q <= cnt_q;
            pre_q <= pre_d;
            idx_q <= idx_d;
            an_q  <= an_d;
        end
    end

    assign q  = q_q;
    assign an = an_q;

endmodule

// File: tb/tb_bcd_multidigito.sv
// Randomised bench for bcd_multidigito against an integer-arithmetic display model,
// with directed literal checks of counting, latching, scanning and blanking.
module tb_bcd_multidigito;

    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;
    localparam int MOD      = 10 ** DIGITS;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    logic                 ck = 1'b0;
    logic                 rst_s = 1'b1;
    logic                 enb = 1'b0;
    logic                 up = 1'b1;
    logic                 ld = 1'b0;
    logic [4*DIGITS-1:0]  q;
    logic [DIGITS-1:0]    an;
    logic [6:0]           sgm;
    logic                 cnt_max;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt = 0, m_q = 0, m_pre = 0, m_idx = 0;
    bit model_valid = 0;

    bcd_multidigito #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .ck(ck), .rst_s(rst_s), .enb(enb), .up(up), .ld(ld),
        .q(q), .an(an), .sgm(sgm), .cnt_max(cnt_max)
    );

    always #5 ck = ~ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_sgm(input int val, input int idx);
        int d;
        d = (val / (10 ** idx)) % 10;
`ifdef BCD_BLANK_EN
        if (idx > 0 && val < 10 ** idx) return 7'b0000000;
`endif
        return SEG_TAB[d];
    endfunction

    // Model: counter and latch as plain integers, scan as a cycle counter.
    always @(posedge ck) begin
        if (rst_s) begin
            m_cnt = 0; m_q = 0; m_pre = 0; m_idx = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (ld) m_q = m_cnt;
            if (enb) m_cnt = up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
            if (m_pre == SCAN_DIV - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % DIGITS;
            end else begin
                m_pre++;
            end
        end
    end

    always @(negedge ck) begin
        if (model_valid) begin
            check("q", q, to_bcd(m_q));
            check("an", an, 1 << m_idx);
            check("sgm", sgm, exp_sgm(m_q, m_idx));
            check("cnt_max", cnt_max, up ? (m_cnt == MOD - 1) : (m_cnt == 0));
        end
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
    endtask

    task automatic steps(input int n);
        enb = 1'b1;
        repeat (n) tick();
        enb = 1'b0;
    endtask

    task automatic load();
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        logic [DIGITS-1:0] prev;
        int run;
        bit seen;

        // Reset state and combinational cnt_max
        do_reset();
        check("rst_q", q, 12'h000);
        check("rst_an", an, 3'b001);
        check("rst_cnt_max", cnt_max, 1'b0);
        up = 1'b0;
        #1;
        check("cnt_max_down_at_0", cnt_max, 1'b1);
        up = 1'b1;

        steps(10);
        load();
        check("q_010", q, 12'h010);

        // Down-wrap from 000, then up-wrap from 999
        do_reset();
        up = 1'b0;
        steps(1);
        load();
        check("q_999", q, 12'h999);
        up = 1'b1;
        #1;
        check("cnt_max_999", cnt_max, 1'b1);
        steps(1);
        check("cnt_max_after_wrap", cnt_max, 1'b0);
        load();
        check("q_wrap_000", q, 12'h000);

        steps(100);
        up = 1'b0;
        steps(1);
        load();
        check("q_099", q, 12'h099);
        up = 1'b1;

        // Latch takes pre-step value when ld and enb coincide
        do_reset();
        steps(41);
        ld = 1'b1; enb = 1'b1;
        tick();
        ld = 1'b0; enb = 1'b0;
        check("q_041", q, 12'h041);
        load();
        check("q_042", q, 12'h042);

        // Scan of 123: each digit held SCAN_DIV cycles, rotating 001->010->100
        do_reset();
        steps(123);
        load();
        check("q_123", q, 12'h123);
        prev = an; run = 1; seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            case (an)
                3'b001:  check("scan_sgm_d0", sgm, SEG_TAB[3]);
                3'b010:  check("scan_sgm_d1", sgm, SEG_TAB[2]);
                3'b100:  check("scan_sgm_d2", sgm, SEG_TAB[1]);
                default: check("scan_an_onehot", an, 3'b001);
            endcase
            if (an == prev) begin
                run++;
            end else begin
                check("scan_order", an, {prev[1:0], prev[2]});
                if (seen) check("scan_dwell", run, SCAN_DIV);
                seen = 1; run = 1; prev = an;
            end
        end

        // Reset mid-scan with enb high
        for (int i = 0; i < 20 && an != 3'b010; i++) tick();
        check("wait_an_010", an, 3'b010);
        enb = 1'b1;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        enb = 1'b0;
        check("midrst_q", q, 12'h000);
        check("midrst_an", an, 3'b001);
        for (int i = 0; i < SCAN_DIV - 1; i++) begin
            tick();
            check("midrst_an_hold", an, 3'b001);
        end
        tick();
        check("midrst_an_next", an, 3'b010);
        load();
        check("midrst_cnt_zero", q, 12'h000);

        // Leading zeros: 007 then 000
        do_reset();
        steps(7);
        load();
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick();
            if (an == 3'b001) check("q007_d0", sgm, SEG_TAB[7]);
`ifdef BCD_BLANK_EN
            else check("q007_blank", sgm, 7'b0000000);
`else
            else check("q007_zero", sgm, SEG_TAB[0]);
`endif
        end
        do_reset();
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick();
            if (an == 3'b001) check("q000_d0", sgm, SEG_TAB[0]);
`ifdef BCD_BLANK_EN
            else check("q000_blank", sgm, 7'b0000000);
`else
            else check("q000_zero", sgm, SEG_TAB[0]);
`endif
        end

        // Random traffic, checked every cycle by the model comparator
        for (int i = 0; i < 4000; i++) begin
            rst_s = ($urandom_range(255) == 0);
            enb   = ($urandom_range(3) != 0);
            ld    = ($urandom_range(7) == 0);
            if ($urandom_range(7) == 0) up = ~up;
            tick();
        end
        rst_s = 1'b0; enb = 1'b0; ld = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
